// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg
//   Shared definitions for the RTC bus responder:
//   - state_t        : responder FSM state encoding
//   - DEFAULT_T_STB  : default strobe-low length per phase, in clocks
//   - DEFAULT_T_REC  : default recovery length after each strobe, in clocks
//   - RTC_ADDR_*     : RTC register addresses used by the user-control block
//   - timer_width()  : phase-counter width for a given T_STB/T_REC pair
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_A_STB    = 3'd1,
    ST_A_REC    = 3'd2,
    ST_D_STB    = 3'd3,
    ST_D_REC    = 3'd4,
    ST_DONE     = 3'd5,
    ST_WAIT_REL = 3'd6
  } state_t;

  localparam int DEFAULT_T_STB = 4;
  localparam int DEFAULT_T_REC = 2;

  localparam logic [7:0] RTC_ADDR_SECONDS = 8'h21;
  localparam logic [7:0] RTC_ADDR_MINUTES = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOURS   = 8'h23;
  localparam logic [7:0] RTC_ADDR_DATE    = 8'h24;
  localparam logic [7:0] RTC_ADDR_MONTH   = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR    = 8'h26;
  localparam logic [7:0] RTC_ADDR_TIMER   = 8'h33;
  localparam logic [7:0] RTC_ADDR_COMMAND = 8'hF0;

  // Width able to hold max(t_stb, t_rec); never below one bit.
  function automatic int timer_width(input int t_stb, input int t_rec);
    int t_max;
    t_max = (t_stb > t_rec) ? t_stb : t_rec;
    return (t_max < 1) ? 1 : $clog2(t_max + 1);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer
//   Down-counter that times every bus phase. Loading sets the count;
//   otherwise it decrements and stops at zero.
//   Ports:
//     clk        in   clock
//     rst_n      in   asynchronous active-low reset
//     load       in   load load_value this edge
//     load_value in   cycles-minus-one for the phase being entered
//     zero       out  count is zero (last cycle of the phase)
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int T_STB = DEFAULT_T_STB,
  parameter int T_REC = DEFAULT_T_REC,
  localparam int CW = timer_width(T_STB, T_REC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
//   Executes one read or write request at a time as a two-phase
//   (address, then data) cycle on the RTC multiplexed A/D bus.
//   Ports:
//     CLK        in   clock
//     reset      in   asynchronous active-low reset
//     read       in   level read request, held until fin
//     escritura  in   level write request, held until fin (wins over read)
//     ADD2       in   RTC register address, captured with the request
//     Dato_out   in   write data, captured with the request
//     Dato_in    out  last read data
//     fin        out  one-cycle transaction-done pulse
//     busy       out  high from request capture until back in IDLE
//     cs_n/rd_n/wr_n out  RTC strobes, active-low
//     ad_sel     out  0 = address phase, 1 = data phase
//     ad_out     out  bus drive value
//     ad_oe      out  bus output enable for the external tristate
//     ad_in      in   bus sample value
//   All outputs come straight from flops.
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int T_STB = DEFAULT_T_STB,
  parameter int T_REC = DEFAULT_T_REC
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       read,
  input  logic       escritura,
  input  logic [7:0] ADD2,
  input  logic [7:0] Dato_out,
  output logic [7:0] Dato_in,
  output logic       fin,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam int CW = timer_width(T_STB, T_REC);
  localparam logic [CW-1:0] STB_LOAD = CW'(T_STB - 1);
  localparam logic [CW-1:0] REC_LOAD = CW'(T_REC - 1);

  state_t        state_reg, state_next;
  logic [7:0]    addr_reg, data_reg;
  logic          write_reg;
  logic          capture;
  logic          timer_load;
  logic [CW-1:0] timer_value;
  logic          timer_zero;

  logic       cs_n_reg, cs_n_next;
  logic       rd_n_reg, rd_n_next;
  logic       wr_n_reg, wr_n_next;
  logic       ad_sel_reg, ad_sel_next;
  logic       ad_oe_reg, ad_oe_next;
  logic [7:0] ad_out_reg, ad_out_next;
  logic       fin_reg, fin_next;
  logic       busy_reg, busy_next;
  logic [7:0] dato_in_reg;

  rtc_phase_timer #(
    .T_STB(T_STB),
    .T_REC(T_REC)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .zero      (timer_zero)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
      write_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        addr_reg  <= ADD2;
        data_reg  <= Dato_out;
        write_reg <= escritura;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    capture     = 1'b0;
    timer_load  = 1'b0;
    timer_value = STB_LOAD;

    case (state_reg)
      ST_IDLE: begin
        if (read || escritura) begin
          capture     = 1'b1;
          timer_load  = 1'b1;
          timer_value = STB_LOAD;
          state_next  = ST_A_STB;
        end
      end
      ST_A_STB: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = REC_LOAD;
          state_next  = ST_A_REC;
        end
      end
      ST_A_REC: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = STB_LOAD;
          state_next  = ST_D_STB;
        end
      end
      ST_D_STB: begin
        if (timer_zero) begin
          timer_load  = 1'b1;
          timer_value = REC_LOAD;
          state_next  = ST_D_REC;
        end
      end
      ST_D_REC: begin
        if (timer_zero) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (!read && !escritura) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Strobes, ad_sel and fin are registered from the current state, so
    // on the pins they trail the state by one cycle.
    cs_n_next   = !((state_reg == ST_A_STB) || (state_reg == ST_D_STB));
    wr_n_next   = !((state_reg == ST_A_STB) ||
                    ((state_reg == ST_D_STB) && write_reg));
    rd_n_next   = !((state_reg == ST_D_STB) && !write_reg);
    ad_sel_next = (state_reg == ST_D_STB) || (state_reg == ST_D_REC);
    fin_next    = (state_reg == ST_DONE);
    busy_next   = (state_next != ST_IDLE);

    // ad_oe is decoded from the next state instead, so it settles one cycle
    // ahead of any falling strobe; for writes it is held through the last
    // low cycle of wr_n and drops together with the strobe rising.
    ad_oe_next = (state_next == ST_A_STB) || (state_next == ST_A_REC) ||
                 (write_reg && ((state_next == ST_D_STB) ||
                                (state_reg == ST_D_STB)));

    // Address goes out with the capture (straight from ADD2, since the
    // latch loads on the same edge); write data replaces it as wr_n falls
    // in the data phase. Otherwise the last value is held.
    ad_out_next = ad_out_reg;
    if (capture) begin
      ad_out_next = ADD2;
    end else if ((state_reg == ST_D_STB) && write_reg) begin
      ad_out_next = data_reg;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cs_n_reg    <= 1'b1;
      rd_n_reg    <= 1'b1;
      wr_n_reg    <= 1'b1;
      ad_sel_reg  <= 1'b0;
      ad_oe_reg   <= 1'b0;
      ad_out_reg  <= '0;
      fin_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      dato_in_reg <= '0;
    end else begin
      cs_n_reg   <= cs_n_next;
      rd_n_reg   <= rd_n_next;
      wr_n_reg   <= wr_n_next;
      ad_sel_reg <= ad_sel_next;
      ad_oe_reg  <= ad_oe_next;
      ad_out_reg <= ad_out_next;
      fin_reg    <= fin_next;
      busy_reg   <= busy_next;
      // Sample the bus on the edge that ends the last rd_n-low cycle.
      if (!rd_n_reg && rd_n_next) begin
        dato_in_reg <= ad_in;
      end
    end
  end

  assign cs_n    = cs_n_reg;
  assign rd_n    = rd_n_reg;
  assign wr_n    = wr_n_reg;
  assign ad_sel  = ad_sel_reg;
  assign ad_oe   = ad_oe_reg;
  assign ad_out  = ad_out_reg;
  assign fin     = fin_reg;
  assign busy    = busy_reg;
  assign Dato_in = dato_in_reg;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder
//   Directed bench for rtc_bus_responder: a default-timing instance and a
//   T_STB=1/T_REC=1 instance. Control outputs are packed as
//   {cs_n, wr_n, rd_n, ad_sel, ad_oe, fin, busy} and compared per cycle
//   against hand-written tables; cycle 0 is the cycle after the edge
//   that samples the request.
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       read, escritura, read1, escritura1;
  logic [7:0] add2, dato_out, ad_in;

  logic [7:0] dato_in, ad_out, dato_in1, ad_out1;
  logic       fin, busy, cs_n, rd_n, wr_n, ad_sel, ad_oe;
  logic       fin1, busy1, cs_n1, rd_n1, wr_n1, ad_sel1, ad_oe1;
  logic [6:0] ctl, ctl1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign ctl  = {cs_n, wr_n, rd_n, ad_sel, ad_oe, fin, busy};
  assign ctl1 = {cs_n1, wr_n1, rd_n1, ad_sel1, ad_oe1, fin1, busy1};

  rtc_bus_responder dut (
    .CLK(clk), .reset(reset), .read(read), .escritura(escritura),
    .ADD2(add2), .Dato_out(dato_out), .Dato_in(dato_in), .fin(fin),
    .busy(busy), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_sel(ad_sel),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  rtc_bus_responder #(.T_STB(1), .T_REC(1)) dut_fast (
    .CLK(clk), .reset(reset), .read(read1), .escritura(escritura1),
    .ADD2(add2), .Dato_out(dato_out), .Dato_in(dato_in1), .fin(fin1),
    .busy(busy1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .ad_sel(ad_sel1),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in)
  );

  task automatic test_reset_values();
    reset = 1'b0; read = 1'b0; escritura = 1'b0; read1 = 1'b0; escritura1 = 1'b0;
    add2 = 8'h00; dato_out = 8'h00; ad_in = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if (ctl !== 7'b1110000 || ad_out !== 8'h00 || dato_in !== 8'h00) begin
      fails++;
      $display("FAIL reset_values: got ctl=%b ad_out=%h dato_in=%h, want ctl=1110000 ad_out=00 dato_in=00", ctl, ad_out, dato_in);
    end
    tests++;
    if (ctl1 !== 7'b1110000 || ad_out1 !== 8'h00 || dato_in1 !== 8'h00) begin
      fails++;
      $display("FAIL reset_values_fast: got ctl=%b ad_out=%h dato_in=%h, want ctl=1110000 ad_out=00 dato_in=00", ctl1, ad_out1, dato_in1);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: got busy=%b cs_n=%b, want busy=0 cs_n=1", busy, cs_n);
    end
    $display("[TB] reset values checked");
  endtask

  task automatic test_write();
    logic [6:0] e;
    logic [7:0] eo;
    add2 = 8'h21; dato_out = 8'h35; escritura = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      @(negedge clk);
      case (i)
        0:           e = 7'b1110101;
        1, 2, 3, 4:  e = 7'b0010101;
        5, 6:        e = 7'b1110101;
        7, 8, 9, 10: e = 7'b0011101;
        11, 12:      e = 7'b1111001;
        default:     e = 7'b1110011;
      endcase
      tests++;
      if (ctl !== e) begin
        fails++;
        $display("FAIL write_ctl cycle %0d: got %b, want %b", i, ctl, e);
      end
      if (e[2]) begin
        eo = (i >= 7) ? 8'h35 : 8'h21;
        tests++;
        if (ad_out !== eo) begin
          fails++;
          $display("FAIL write_ad_out cycle %0d: got %h, want %h", i, ad_out, eo);
        end
      end
      // Changing inputs mid-transaction must not affect the bus.
      if (i == 2) begin
        add2 = 8'hFF; dato_out = 8'h00;
      end
    end
    escritura = 1'b0;
    tests++;
    if (dato_in !== 8'h00) begin
      fails++;
      $display("FAIL write_dato_in: got %h, want 00", dato_in);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || fin !== 1'b0) begin
      fails++;
      $display("FAIL write_release: got busy=%b fin=%b, want 0 0", busy, fin);
    end
    $display("[TB] write 0x21<=0x35 transaction checked");
  endtask

  task automatic test_read();
    logic [6:0] e;
    add2 = 8'h24; ad_in = 8'h11; read = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      @(negedge clk);
      case (i)
        0:           e = 7'b1110101;
        1, 2, 3, 4:  e = 7'b0010101;
        5:           e = 7'b1110101;
        6:           e = 7'b1110001;
        7, 8, 9, 10: e = 7'b0101001;
        11, 12:      e = 7'b1111001;
        default:     e = 7'b1110011;
      endcase
      tests++;
      if (ctl !== e) begin
        fails++;
        $display("FAIL read_ctl cycle %0d: got %b, want %b", i, ctl, e);
      end
      if (i <= 4) begin
        tests++;
        if (ad_out !== 8'h24) begin
          fails++;
          $display("FAIL read_ad_out cycle %0d: got %h, want 24", i, ad_out);
        end
      end
      if (i == 10) ad_in = 8'h47;
      if (i == 11) ad_in = 8'h00;
      if (i == 13) begin
        tests++;
        if (dato_in !== 8'h47) begin
          fails++;
          $display("FAIL read_dato_in_at_fin: got %h, want 47", dato_in);
        end
      end
    end
    read = 1'b0;
    @(negedge clk);
    tests++;
    if (dato_in !== 8'h47 || busy !== 1'b0) begin
      fails++;
      $display("FAIL read_hold: got dato_in=%h busy=%b, want 47 0", dato_in, busy);
    end
    $display("[TB] read 0x24 -> 0x47 transaction checked");
  endtask

  task automatic test_held_request();
    int fin_cnt, fin_at, bursts;
    logic prev_rd;
    fin_cnt = 0; fin_at = -1; bursts = 0; prev_rd = 1'b1;
    add2 = 8'h25; ad_in = 8'h3C; read = 1'b1;
    for (int i = 0; i <= 43; i++) begin
      @(negedge clk);
      if (fin === 1'b1) begin fin_cnt++; fin_at = i; end
      if (rd_n === 1'b0 && prev_rd === 1'b1) bursts++;
      prev_rd = rd_n;
    end
    tests++;
    if (fin_cnt != 1 || fin_at != 13) begin
      fails++;
      $display("FAIL held_fin: got count=%0d at=%0d, want count=1 at=13", fin_cnt, fin_at);
    end
    tests++;
    if (bursts != 1) begin
      fails++;
      $display("FAIL held_rd_bursts: got %0d, want 1", bursts);
    end
    tests++;
    if (busy !== 1'b1 || dato_in !== 8'h3C) begin
      fails++;
      $display("FAIL held_state: got busy=%b dato_in=%h, want 1 3C", busy, dato_in);
    end
    read = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL held_release: got busy=%b, want 0", busy);
    end
    // Reassert: a second transaction must run.
    ad_in = 8'h5E; read = 1'b1;
    fin_cnt = 0; fin_at = -1; bursts = 0; prev_rd = 1'b1;
    for (int i = 0; i <= 40 && fin_cnt == 0; i++) begin
      @(negedge clk);
      if (fin === 1'b1) begin fin_cnt++; fin_at = i; end
      if (rd_n === 1'b0 && prev_rd === 1'b1) bursts++;
      prev_rd = rd_n;
    end
    tests++;
    if (fin_cnt != 1 || fin_at != 13 || bursts != 1) begin
      fails++;
      $display("FAIL held_second: got fin=%0d at=%0d bursts=%0d, want fin=1 at=13 bursts=1", fin_cnt, fin_at, bursts);
    end
    tests++;
    if (dato_in !== 8'h5E) begin
      fails++;
      $display("FAIL held_second_data: got %h, want 5E", dato_in);
    end
    read = 1'b0;
    @(negedge clk);
    $display("[TB] held read request checked");
  endtask

  task automatic test_both_requests();
    int wr_data, rd_low, bad_out, fin_at;
    wr_data = 0; rd_low = 0; bad_out = 0; fin_at = -1;
    add2 = 8'h22; dato_out = 8'h5A; ad_in = 8'hA5;
    read = 1'b1; escritura = 1'b1;
    for (int i = 0; i <= 13; i++) begin
      @(negedge clk);
      if (wr_n === 1'b0 && ad_sel === 1'b1) begin
        wr_data++;
        if (ad_out !== 8'h5A) bad_out++;
      end
      if (rd_n === 1'b0) rd_low++;
      if (fin === 1'b1 && fin_at < 0) fin_at = i;
    end
    tests++;
    if (wr_data != 4 || rd_low != 0) begin
      fails++;
      $display("FAIL both_strobes: got wr_data=%0d rd_low=%0d, want 4 0", wr_data, rd_low);
    end
    tests++;
    if (bad_out != 0 || fin_at != 13) begin
      fails++;
      $display("FAIL both_data: got bad_out=%0d fin_at=%0d, want 0 13", bad_out, fin_at);
    end
    tests++;
    if (dato_in !== 8'h5E) begin
      fails++;
      $display("FAIL both_dato_in: got %h, want 5E", dato_in);
    end
    read = 1'b0; escritura = 1'b0;
    @(negedge clk);
    $display("[TB] simultaneous read+write request checked");
  endtask

  task automatic test_sweep();
    logic [6:0] e;
    logic [7:0] eo;
    int rd_low, fin_at;
    add2 = 8'h26; dato_out = 8'h99; escritura1 = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      case (i)
        0:       e = 7'b1110101;
        1:       e = 7'b0010101;
        2:       e = 7'b1110101;
        3:       e = 7'b0011101;
        4:       e = 7'b1111001;
        default: e = 7'b1110011;
      endcase
      tests++;
      if (ctl1 !== e) begin
        fails++;
        $display("FAIL sweep_ctl cycle %0d: got %b, want %b", i, ctl1, e);
      end
      if (e[2]) begin
        eo = (i == 3) ? 8'h99 : 8'h26;
        tests++;
        if (ad_out1 !== eo) begin
          fails++;
          $display("FAIL sweep_ad_out cycle %0d: got %h, want %h", i, ad_out1, eo);
        end
      end
    end
    escritura1 = 1'b0;
    @(negedge clk);
    tests++;
    if (busy1 !== 1'b0) begin
      fails++;
      $display("FAIL sweep_release: got busy=%b, want 0", busy1);
    end
    rd_low = 0; fin_at = -1;
    add2 = 8'h23; ad_in = 8'hC3; read1 = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (rd_n1 === 1'b0) rd_low++;
      if (fin1 === 1'b1 && fin_at < 0) fin_at = i;
    end
    tests++;
    if (rd_low != 1 || fin_at != 5 || dato_in1 !== 8'hC3) begin
      fails++;
      $display("FAIL sweep_read: got rd_low=%0d fin_at=%0d dato_in=%h, want 1 5 C3", rd_low, fin_at, dato_in1);
    end
    read1 = 1'b0;
    @(negedge clk);
    $display("[TB] T_STB=1 T_REC=1 sweep checked");
  endtask

  task automatic test_reset_midrun();
    int active;
    add2 = 8'h23; dato_out = 8'h77; escritura = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (cs_n !== 1'b0) begin
      fails++;
      $display("FAIL midrun_strobe: got cs_n=%b, want 0", cs_n);
    end
    #2;
    reset = 1'b0; escritura = 1'b0;
    #1;
    tests++;
    if (ctl !== 7'b1110000 || ad_out !== 8'h00 || dato_in !== 8'h00) begin
      fails++;
      $display("FAIL midrun_reset: got ctl=%b ad_out=%h dato_in=%h, want 1110000 00 00", ctl, ad_out, dato_in);
    end
    @(negedge clk);
    reset = 1'b1;
    active = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || cs_n !== 1'b1 || ad_oe !== 1'b0) active++;
    end
    tests++;
    if (active != 0) begin
      fails++;
      $display("FAIL midrun_no_resume: got %0d active cycles, want 0", active);
    end
    $display("[TB] reset mid-transaction checked");
  endtask

  initial begin
    test_reset_values();
    test_write();
    test_read();
    test_held_request();
    test_both_requests();
    test_sweep();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Bus-side responder for the user-control block. It accepts one read or write request at a time (8-bit RTC address `ADD2`, write data `Dato_out`) and executes it as a two-phase cycle on the RTC multiplexed address/data bus. It returns read data on `Dato_in` and acknowledges each request with a one-cycle `fin` pulse. It sits between `controldeususario` and the RTC pins.

## Interface
Parameters:
- `T_STB`, 4: strobe-low length in clocks, per phase (≥1).
- `T_REC`, 2: recovery length in clocks after each strobe, strobes high (≥1).

Ports:
- `CLK`  in  1  single clock.
- `reset`  in  1  asynchronous, active-low reset.
- `read`  in  1  level read request from the user control; held until `fin`.
- `escritura`  in  1  level write request; held until `fin`.
- `ADD2`  in  8  RTC register address for the request.
- `Dato_out`  in  8  write data; captured with the request.
- `Dato_in`  out  8  last read data, registered.
- `fin`  out  1  one-cycle transaction-done pulse.
- `busy`  out  1  high from request capture until back in IDLE.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  RTC strobes, active-low.
- `ad_sel`  out  1  0 = address phase, 1 = data phase (RTC A/D pin).
- `ad_out`  out  8  bus drive value.
- `ad_oe`  out  1  bus output enable; top-level tristate uses it.
- `ad_in`  in  8  bus sample value.

## Operation
- FSM states:
  - IDLE
  - A_STB (address strobe)
  - A_REC (address recovery)
  - D_STB (data strobe)
  - D_REC (data recovery)
  - DONE
  - WAIT_REL
- IDLE:
  - Samples `read`/`escritura` every edge.
  - On a request, latches `ADD2`, `Dato_out` and the op into internal registers, then goes to A_STB.
  - If both are high, the op is a write.
- A_STB: `cs_n`=0, `wr_n`=0, `ad_sel`=0, `ad_oe`=1, `ad_out`=latched address; lasts T_STB cycles.
- A_REC: all strobes high, `ad_oe` stays 1, address still driven; lasts T_REC cycles.
- D_STB, write: `cs_n`=0, `wr_n`=0, `ad_sel`=1, `ad_oe`=1, `ad_out`=latched data.
- D_STB, read: `cs_n`=0, `rd_n`=0, `ad_sel`=1, `ad_oe`=0.
  - `ad_in` is registered into `Dato_in` on the clock edge that ends the last D_STB cycle.
- D_REC: strobes high, `ad_oe`=0, T_REC cycles.
- DONE: `fin`=1 for exactly one cycle, then go to WAIT_REL.
- WAIT_REL:
  - Stays until `read`=0 and `escritura`=0 are sampled, then goes to IDLE.
  - A request held past `fin` never starts a second transaction.
- Outputs:
  - `busy`=1 in every state except IDLE.
  - Writes leave `Dato_in` unchanged.
  - Input changes during a transaction are ignored; the latched values are used.
- A single down-counter, loaded on each phase entry, times every phase.

## Timing
- Reset values (asynchronous on `reset`=0, regardless of state):
  - State = IDLE.
  - `cs_n`=`rd_n`=`wr_n`=1.
  - `ad_sel`=0, `ad_oe`=0, `ad_out`=0.
  - `Dato_in`=0, `fin`=0, `busy`=0.
- Reset mid-transaction releases all strobes immediately (combinational path through the async clear). No partial cycle resumes after reset.
- Latency:
  - Request sampled at edge k → `fin` high during cycle k+2·(T_STB+T_REC)+1.
  - With defaults, `fin` is high 13 cycles after the sampling edge.
- Read data is valid on `Dato_in` in the same cycle `fin` is high, and is held until the next completed read.
- `ad_oe` never changes value in the same cycle a strobe falls.
- All outputs are registered: decoded from state, no combinational path from inputs.
- Minimum spacing between transactions: `fin`, 1 WAIT_REL cycle with requests low, then an IDLE sample.

## Structure
- Package `rtc_bus_pkg` contains:
  - FSM state encoding.
  - Default `T_STB`/`T_REC` constants.
  - RTC register address constants (seconds, minutes, hours, date, month, year, timer, command).
- One sub-module, `rtc_phase_timer`:
  - Parameterised down-counter with a load input and a `zero` flag.
  - Counter width is `$clog2` of max(T_STB, T_REC)+1.
- Top-level tristate for `AD` is outside this block.

## Test plan
- Reset: drive `reset`=0 mid-run → all outputs equal reset values within the same cycle; release → IDLE, `busy`=0.
- Write: `escritura`=1, `ADD2`=0x21, `Dato_out`=0x35, defaults →
  - Address phase: 4 cycles `cs_n`/`wr_n` low with `ad_sel`=0, `ad_out`=0x21.
  - 2 recovery cycles.
  - Data phase: 4 cycles `wr_n` low with `ad_sel`=1, `ad_out`=0x35.
  - `fin` pulses 13 cycles after capture; `Dato_in` unchanged.
- Read: `read`=1, `ADD2`=0x24, `ad_in`=0x47 during D_STB →
  - `rd_n` low 4 cycles with `ad_oe`=0.
  - `Dato_in`=0x47 when `fin`=1.
  - `ad_in` changed to 0x00 after D_STB does not alter `Dato_in`.
- Held request: keep `read`=1 for 30 cycles after `fin` → exactly one `fin` and one `rd_n` burst; drop `read`, reassert → second transaction starts.
- Both requests: `read`=`escritura`=1, `ADD2`=0x22 → write cycle (`wr_n` in data phase, `rd_n` stays 1).
- Parameter sweep: T_STB=1, T_REC=1 → `fin` at k+5; strobe widths exactly 1 cycle.
